// File: rtl/l1d_writeback_buffer.sv
// L1D writeback/eviction buffer: write FIFO toward the lower cache, read-miss bypass, store-to-load forwarding.
// Optional feature: define L1D_WB_COALESCE_EN to merge a write into the youngest matching queued entry.
module l1d_writeback_buffer #(
    parameter int PADDR_BITS = 22,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_N_in,
    input  logic                  l1_valid_in,
    output logic                  l1_ready_out,
    input  logic [PADDR_BITS-1:0] l1_addr_in,
    input  logic [63:0]           l1_value_in,
    input  logic                  l1_we_in,
    output logic                  l1_valid_out,
    input  logic                  l1_ready_in,
    output logic [PADDR_BITS-1:0] l1_addr_out,
    output logic [63:0]           l1_value_out,
    output logic                  lc_valid_out,
    input  logic                  lc_ready_in,
    output logic [PADDR_BITS-1:0] lc_addr_out,
    output logic [63:0]           lc_value_out,
    output logic                  lc_we_out,
    input  logic                  lc_valid_in,
    output logic                  lc_ready_out,
    input  logic [PADDR_BITS-1:0] lc_addr_in,
    input  logic [63:0]           lc_value_in,
    output logic                  empty_out
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PADDR_BITS-1:0] addr;
        logic [63:0]           data;
    } entry_t;

    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [PADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic                  wr_busy_q, wr_busy_d;
    logic                  fwd_valid_q, fwd_valid_d;
    entry_t                fwd_q, fwd_d;
    entry_t                mem_q [DEPTH];
    entry_t                mem_d [DEPTH];

    logic [DEPTH-1:0] live, match;
    logic             hit;
    logic [PW-1:0]    hit_idx;
    logic             pres_rd, acc, wr_acc, rd_acc, deq, coal, enq;

    // Entry i is live when its distance from head is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_cam
        logic [PW-1:0] age;
        assign age      = PW'(i) - head_q;
        assign live[i]  = CW'(age) < count_q;
        assign match[i] = live[i] && (mem_q[i].addr == l1_addr_in);
    end

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (match[head_q + PW'(k)]) begin
                hit     = 1'b1;
                hit_idx = head_q + PW'(k);
            end
        end
    end

    // A write that stalled while presented keeps the port until it retires, so a later read waits.
    assign pres_rd      = rd_valid_q && !wr_busy_q;
    assign lc_valid_out = rd_valid_q || (count_q != '0);
    assign lc_we_out    = !pres_rd && (count_q != '0);
    assign lc_addr_out  = pres_rd ? rd_addr_q : mem_q[head_q].addr;
    assign lc_value_out = pres_rd ? 64'd0 : mem_q[head_q].data;

    assign l1_ready_out = (count_q < CW'(DEPTH)) && !rd_valid_q && !fwd_valid_q;
    assign acc          = l1_valid_in && l1_ready_out;
    assign wr_acc       = acc && l1_we_in;
    assign rd_acc       = acc && !l1_we_in;
    assign deq          = lc_ready_in && lc_we_out;

`ifdef L1D_WB_COALESCE_EN
    assign coal = wr_acc && hit && !(hit_idx == head_q && lc_valid_out && lc_we_out);
`else
    assign coal = 1'b0;
`endif
    assign enq = wr_acc && !coal;

    assign l1_valid_out = fwd_valid_q || lc_valid_in;
    assign l1_addr_out  = fwd_valid_q ? fwd_q.addr : lc_addr_in;
    assign l1_value_out = fwd_valid_q ? fwd_q.data : lc_value_in;
    assign lc_ready_out = l1_ready_in && !fwd_valid_q;
    assign empty_out    = (count_q == '0) && !rd_valid_q;

    always_comb begin
        head_d    = head_q + PW'(deq);
        tail_d    = tail_q + PW'(enq);
        count_d   = count_q + CW'(enq) - CW'(deq);
        wr_busy_d = lc_we_out && !lc_ready_in;
        rd_addr_d = rd_addr_q;
        if (rd_valid_q) begin
            rd_valid_d = !(pres_rd && lc_ready_in);
        end else begin
            rd_valid_d = rd_acc && !hit;
            if (rd_acc && !hit) rd_addr_d = l1_addr_in;
        end
        fwd_d       = fwd_q;
        fwd_valid_d = fwd_valid_q ? !l1_ready_in : (rd_acc && hit);
        if (rd_acc && hit) fwd_d = mem_q[hit_idx];
        mem_d = mem_q;
        if (enq)  mem_d[tail_q] = '{addr: l1_addr_in, data: l1_value_in};
        if (coal) mem_d[hit_idx].data = l1_value_in;
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            rd_addr_q   <= '0;
            wr_busy_q   <= 1'b0;
            fwd_valid_q <= 1'b0;
            fwd_q       <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            rd_addr_q   <= rd_addr_d;
            wr_busy_q   <= wr_busy_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_q       <= fwd_d;
        end
    end

    // Entry storage needs no reset; liveness comes from head/count.
    always_ff @(posedge clk_in) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_l1d_writeback_buffer.sv
// Directed bench for l1d_writeback_buffer: per-cycle vector table plus reset and coalesce sequences.
module tb_l1d_writeback_buffer;
    logic        clk_in = 1'b0;
    logic        rst_N_in;
    logic        l1_valid_in, l1_we_in, l1_ready_in, lc_ready_in, lc_valid_in;
    logic [21:0] l1_addr_in, lc_addr_in;
    logic [63:0] l1_value_in, lc_value_in;
    logic        l1_ready_out, l1_valid_out, lc_valid_out, lc_we_out, lc_ready_out, empty_out;
    logic [21:0] l1_addr_out, lc_addr_out;
    logic [63:0] l1_value_out, lc_value_out;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk_in = ~clk_in;

    l1d_writeback_buffer #(.PADDR_BITS(22), .DEPTH(4)) dut (
        .clk_in(clk_in), .rst_N_in(rst_N_in),
        .l1_valid_in(l1_valid_in), .l1_ready_out(l1_ready_out), .l1_addr_in(l1_addr_in),
        .l1_value_in(l1_value_in), .l1_we_in(l1_we_in),
        .l1_valid_out(l1_valid_out), .l1_ready_in(l1_ready_in), .l1_addr_out(l1_addr_out),
        .l1_value_out(l1_value_out),
        .lc_valid_out(lc_valid_out), .lc_ready_in(lc_ready_in), .lc_addr_out(lc_addr_out),
        .lc_value_out(lc_value_out), .lc_we_out(lc_we_out),
        .lc_valid_in(lc_valid_in), .lc_ready_out(lc_ready_out), .lc_addr_in(lc_addr_in),
        .lc_value_in(lc_value_in), .empty_out(empty_out)
    );

    typedef struct {
        string       name;
        logic        vi;  logic [21:0] ai;  logic [63:0] di;  logic wei;
        logic        l1r; logic lcr;
        logic        lcv; logic [21:0] lca; logic [63:0] lcd;
        logic        e_rdy; logic e_lcv; logic [21:0] e_lca; logic [63:0] e_lcd; logic e_we;
        logic        e_l1v; logic [21:0] e_l1a; logic [63:0] e_l1d; logic e_lcr; logic e_emp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(string n, logic vi, logic [21:0] ai, logic [63:0] di, logic wei,
                               logic l1r, logic lcr, logic lcv, logic [21:0] lca, logic [63:0] lcd,
                               logic er, logic elcv, logic [21:0] elca, logic [63:0] elcd, logic ewe,
                               logic el1v, logic [21:0] el1a, logic [63:0] el1d, logic elcr, logic eemp);
        vec_t t;
        t.name = n; t.vi = vi; t.ai = ai; t.di = di; t.wei = wei;
        t.l1r = l1r; t.lcr = lcr; t.lcv = lcv; t.lca = lca; t.lcd = lcd;
        t.e_rdy = er; t.e_lcv = elcv; t.e_lca = elca; t.e_lcd = elcd; t.e_we = ewe;
        t.e_l1v = el1v; t.e_l1a = el1a; t.e_l1d = el1d; t.e_lcr = elcr; t.e_emp = eemp;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
        else n_pass++;
    endtask

    // One cycle: drive at negedge, check combinational outputs before the next posedge.
    task automatic step(input vec_t t);
        @(negedge clk_in);
        l1_valid_in = t.vi; l1_addr_in = t.ai; l1_value_in = t.di; l1_we_in = t.wei;
        l1_ready_in = t.l1r; lc_ready_in = t.lcr;
        lc_valid_in = t.lcv; lc_addr_in = t.lca; lc_value_in = t.lcd;
        #1;
        chk({t.name, ".l1_ready"}, 64'(l1_ready_out), 64'(t.e_rdy));
        chk({t.name, ".lc_valid"}, 64'(lc_valid_out), 64'(t.e_lcv));
        chk({t.name, ".empty"},    64'(empty_out),    64'(t.e_emp));
        chk({t.name, ".l1_valid"}, 64'(l1_valid_out), 64'(t.e_l1v));
        chk({t.name, ".lc_ready"}, 64'(lc_ready_out), 64'(t.e_lcr));
        if (t.e_lcv) begin
            chk({t.name, ".lc_addr"},  64'(lc_addr_out), 64'(t.e_lca));
            chk({t.name, ".lc_value"}, lc_value_out,     t.e_lcd);
            chk({t.name, ".lc_we"},    64'(lc_we_out),   64'(t.e_we));
        end
        if (t.e_l1v) begin
            chk({t.name, ".l1_addr"},  64'(l1_addr_out), 64'(t.e_l1a));
            chk({t.name, ".l1_value"}, l1_value_out,     t.e_l1d);
        end
    endtask

    initial begin
        rst_N_in = 1'b0;
        l1_valid_in = 0; l1_addr_in = 0; l1_value_in = 0; l1_we_in = 0;
        l1_ready_in = 1; lc_ready_in = 1; lc_valid_in = 1; lc_addr_in = 22'h3AB; lc_value_in = 64'h11;

        // name vi ai di we | l1r lcr | lcv lca lcd | rdy lcv lca lcd we | l1v l1a l1d lcr emp
        tbl.push_back(v("w100_acc",     1,'h100,'hAA,1, 1,1, 0,0,0,        1,0,0,0,0,          0,0,0,1,1));
        tbl.push_back(v("w100_out",     0,0,0,0,        1,1, 0,0,0,        1,1,'h100,'hAA,1,   0,0,0,1,0));
        tbl.push_back(v("w100_empty",   0,0,0,0,        1,1, 0,0,0,        1,0,0,0,0,          0,0,0,1,1));
        tbl.push_back(v("w10",          1,'h10,1,1,     1,0, 0,0,0,        1,0,0,0,0,          0,0,0,1,1));
        tbl.push_back(v("w20",          1,'h20,2,1,     1,0, 0,0,0,        1,1,'h10,1,1,       0,0,0,1,0));
        tbl.push_back(v("w30",          1,'h30,3,1,     1,0, 0,0,0,        1,1,'h10,1,1,       0,0,0,1,0));
        tbl.push_back(v("w40",          1,'h40,4,1,     1,0, 0,0,0,        1,1,'h10,1,1,       0,0,0,1,0));
        tbl.push_back(v("full_block",   1,'h60,6,1,     1,0, 0,0,0,        0,1,'h10,1,1,       0,0,0,1,0));
        tbl.push_back(v("drain10",      0,0,0,0,        1,1, 0,0,0,        0,1,'h10,1,1,       0,0,0,1,0));
        tbl.push_back(v("drain20_enq",  1,'h50,5,1,     1,1, 0,0,0,        1,1,'h20,2,1,       0,0,0,1,0));
        tbl.push_back(v("drain30",      0,0,0,0,        1,1, 0,0,0,        1,1,'h30,3,1,       0,0,0,1,0));
        tbl.push_back(v("drain40",      0,0,0,0,        1,1, 0,0,0,        1,1,'h40,4,1,       0,0,0,1,0));
        tbl.push_back(v("drain50",      0,0,0,0,        1,1, 0,0,0,        1,1,'h50,5,1,       0,0,0,1,0));
        tbl.push_back(v("drain_empty",  0,0,0,0,        1,1, 0,0,0,        1,0,0,0,0,          0,0,0,1,1));
        tbl.push_back(v("w200a",        1,'h200,1,1,    1,0, 0,0,0,        1,0,0,0,0,          0,0,0,1,1));
        tbl.push_back(v("w200b",        1,'h200,2,1,    1,0, 0,0,0,        1,1,'h200,1,1,      0,0,0,1,0));
        tbl.push_back(v("r200_acc",     1,'h200,0,0,    0,0, 0,0,0,        1,1,'h200,1,1,      0,0,0,0,0));
        tbl.push_back(v("fwd_hold",     0,0,0,0,        0,0, 1,'h399,'h77, 0,1,'h200,1,1,      1,'h200,2,0,0));
        tbl.push_back(v("fwd_ack",      0,0,0,0,        1,0, 1,'h399,'h77, 0,1,'h200,1,1,      1,'h200,2,0,0));
        tbl.push_back(v("lc_resp_pass", 0,0,0,0,        1,0, 1,'h399,'h77, 1,1,'h200,1,1,      1,'h399,'h77,1,0));
        tbl.push_back(v("drain200a",    0,0,0,0,        1,1, 0,0,0,        1,1,'h200,1,1,      0,0,0,1,0));
        tbl.push_back(v("drain200b",    0,0,0,0,        1,1, 0,0,0,        1,1,'h200,2,1,      0,0,0,1,0));
        tbl.push_back(v("fwd_no_read",  0,0,0,0,        1,1, 0,0,0,        1,0,0,0,0,          0,0,0,1,1));
        tbl.push_back(v("w300",         1,'h300,'h33,1, 1,0, 0,0,0,        1,0,0,0,0,          0,0,0,1,1));
        tbl.push_back(v("r400_acc",     1,'h400,0,0,    1,0, 0,0,0,        1,1,'h300,'h33,1,   0,0,0,1,0));
        tbl.push_back(v("r400_behind",  0,0,0,0,        1,0, 0,0,0,        0,1,'h300,'h33,1,   0,0,0,1,0));
        tbl.push_back(v("w300_retire",  0,0,0,0,        1,1, 0,0,0,        0,1,'h300,'h33,1,   0,0,0,1,0));
        tbl.push_back(v("r400_pres",    0,0,0,0,        1,0, 0,0,0,        0,1,'h400,0,0,      0,0,0,1,0));
        tbl.push_back(v("r400_retire",  0,0,0,0,        1,1, 0,0,0,        0,1,'h400,0,0,      0,0,0,1,0));
        tbl.push_back(v("r400_resp",    0,0,0,0,        1,0, 1,'h400,'h55, 1,0,0,0,0,          1,'h400,'h55,1,1));

        // Reset state, with a live lower-cache response passing straight through.
        @(negedge clk_in); #1;
        chk("rst.l1_ready", 64'(l1_ready_out), 64'd1);
        chk("rst.lc_valid", 64'(lc_valid_out), 64'd0);
        chk("rst.empty",    64'(empty_out),    64'd1);
        chk("rst.l1_valid", 64'(l1_valid_out), 64'd1);
        chk("rst.l1_value", l1_value_out,      64'h11);
        @(negedge clk_in);
        rst_N_in = 1'b1; lc_valid_in = 0;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Reset while writes are queued discards them.
        step(v("mr_w700", 1,'h700,7,1, 1,0, 0,0,0, 1,0,0,0,0,    0,0,0,1,1));
        step(v("mr_w710", 1,'h710,8,1, 1,0, 0,0,0, 1,1,'h700,7,1, 0,0,0,1,0));
        @(negedge clk_in);
        l1_valid_in = 0; rst_N_in = 1'b0; #1;
        chk("midrst.lc_valid", 64'(lc_valid_out), 64'd0);
        chk("midrst.empty",    64'(empty_out),    64'd1);
        chk("midrst.l1_ready", 64'(l1_ready_out), 64'd1);
        @(negedge clk_in);
        rst_N_in = 1'b1;
        step(v("midrst_after", 0,0,0,0, 1,1, 0,0,0, 1,0,0,0,0, 0,0,0,1,1));

        // Same-address writes behind a stalled head.
        step(v("cw500",  1,'h500,1,1, 1,0, 0,0,0, 1,0,0,0,0,      0,0,0,1,1));
        step(v("cw600a", 1,'h600,2,1, 1,0, 0,0,0, 1,1,'h500,1,1,  0,0,0,1,0));
        step(v("cw600b", 1,'h600,3,1, 1,0, 0,0,0, 1,1,'h500,1,1,  0,0,0,1,0));
        step(v("cd500",  0,0,0,0,     1,1, 0,0,0, 1,1,'h500,1,1,  0,0,0,1,0));
`ifdef L1D_WB_COALESCE_EN
        step(v("cd600",  0,0,0,0,     1,1, 0,0,0, 1,1,'h600,3,1,  0,0,0,1,0));
`else
        step(v("cd600a", 0,0,0,0,     1,1, 0,0,0, 1,1,'h600,2,1,  0,0,0,1,0));
        step(v("cd600b", 0,0,0,0,     1,1, 0,0,0, 1,1,'h600,3,1,  0,0,0,1,0));
`endif
        step(v("cd_empty", 0,0,0,0,   1,1, 0,0,0, 1,0,0,0,0,      0,0,0,1,1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/l1d_writeback_buffer.md
# l1d_writeback_buffer

Write/eviction buffer between the L1 data cache and the lower-level cache. It accepts the L1's writeback and read-miss requests, holds up to DEPTH writes in a FIFO, and issues them downstream. Reads have priority over queued writes. A read that hits a buffered write is answered locally with that write's data. The block also passes lower-level responses back up to the L1.

## Interface
- PADDR_BITS, 22, physical address width
- DEPTH, 4, write FIFO entries (power of two, ≥2)
- clk_in  input  1  clock
- rst_N_in  input  1  reset, asynchronous, active-low
- l1_valid_in  input  1  request from L1 valid
- l1_ready_out  output  1  buffer can accept a request
- l1_addr_in  input  PADDR_BITS  request address
- l1_value_in  input  64  write data
- l1_we_in  input  1  1 = writeback/write, 0 = read miss
- l1_valid_out  output  1  response to L1 valid
- l1_ready_in  input  1  L1 accepts the response
- l1_addr_out  output  PADDR_BITS  response address
- l1_value_out  output  64  response data
- lc_valid_out  output  1  downstream request valid
- lc_ready_in  input  1  lower cache accepts the request
- lc_addr_out  output  PADDR_BITS  downstream address
- lc_value_out  output  64  downstream write data
- lc_we_out  output  1  downstream write enable
- lc_valid_in  input  1  lower-cache response valid
- lc_ready_out  output  1  buffer accepts the response
- lc_addr_in  input  PADDR_BITS  response address
- lc_value_in  input  64  response data
- empty_out  output  1  FIFO empty and no read pending (drain/fence status)

## Operation
- State:
  - write FIFO: head, tail, count; count is $clog2(DEPTH+1) bits; pointers wrap modulo DEPTH;
  - read holding register rd_valid/rd_addr;
  - forward register fwd_valid/fwd_addr/fwd_data.
- Acceptance:
  - A request is accepted when l1_valid_in && l1_ready_out.
  - l1_ready_out = (count<DEPTH) && !rd_valid && !fwd_valid, independent of l1_we_in.
  - No enqueue when full, even if a dequeue happens in the same cycle.
- Write accept: enqueue {addr, data} at tail, tail++, count++.
- Read accept, forward case:
  - CAM-compare l1_addr_in against all valid FIFO entries. This includes the head even if it dequeues that cycle.
  - On a match: load fwd_* with the youngest matching entry's data. Nothing is sent downstream.
- Read accept, miss case: no match loads rd_valid=1, rd_addr.
- Downstream issue:
  - If rd_valid: present the read (lc_we_out=0, lc_value_out=0). Otherwise, if count>0: present the head write (lc_we_out=1).
  - lc_valid_out = rd_valid || count>0.
  - Outputs are driven combinationally from registered state.
  - On lc_ready_in, retire the presented item: clear rd_valid, or head++ and count--.
- Response path:
  - l1_valid_out = fwd_valid || lc_valid_in.
  - When fwd_valid, l1_addr_out/l1_value_out come from fwd_*; otherwise they come from lc_addr_in/lc_value_in.
  - lc_ready_out = l1_ready_in && !fwd_valid.
  - fwd_valid clears on l1_ready_in.
- empty_out = (count==0) && !rd_valid.

## Timing
- Reset (async): all pointers, count, rd_valid and fwd_valid are 0. FIFO data is don't-care. Resulting outputs:
  - l1_ready_out=1, lc_valid_out=0, l1_valid_out=lc_valid_in, empty_out=1.
- Reset mid-operation discards all queued writes and pending reads.
- Write accepted in cycle N: eligible for lc_valid_out in cycle N+1.
- Read miss accepted in cycle N: lc_valid_out with we=0 in cycle N+1.
- Forwarded read accepted in cycle N: l1_valid_out in cycle N+1, held until l1_ready_in.
- Presented lc_* are stable while lc_valid_out && !lc_ready_in, with one exception:
  - A newly arriving read cannot preempt a presented write, because reads are accepted only when rd_valid=0 and that write is already presented.
  - The read is instead registered and presented after the write retires, or immediately if the write retires the same cycle.
- Write order downstream equals acceptance order. A read may overtake older non-matching writes.
- Simultaneous enqueue and dequeue (not full): count is unchanged, both pointers advance.

## Configuration
- L1D_WB_COALESCE_EN defined:
  - A write whose address matches a valid entry overwrites that entry's data in place instead of enqueueing (youngest match).
  - Exception: if the match is the head while lc_valid_out && lc_we_out, a new entry is allocated so presented data stays stable.
- Undefined: every write allocates a new entry.

## Test plan
- Reset, then a write 0x100/0xAA with lc_ready_in=1 -> lc_valid_out=1, lc_we_out=1, addr 0x100, data 0xAA one cycle later; empty_out returns to 1.
- lc_ready_in=0 and 4 writes -> l1_ready_out=0 after the 4th; raise lc_ready_in -> drains in order 0x10, 0x20, 0x30, 0x40; ready is 1 again after the first retire.
- Writes 0x200/1 then 0x200/2 (no coalesce), lc stalled; read 0x200 -> l1_valid_out next cycle with value 2, addr 0x200, lc gets no read.
- Write 0x300 stalled at head, read 0x400 -> after the write retires, lc sees the read (we=0); lc response 0x400/0x55 -> l1_valid_out with 0x55.
- fwd_valid high while lc_valid_in=1 -> forward response delivered first, lc_ready_out=0 until l1_ready_in.
- With L1D_WB_COALESCE_EN: lc stalled, writes 0x500/1, 0x600/2, 0x600/3 -> count=2, drain gives 0x500/1, 0x600/3.
